// File: rtl/gpio_apb_arbiter_if.sv
// Requester command/response lanes and APB master signals shared by the GPIO arbiter.
// The master modport is the arbiter side; the slave modport is the requesters plus APB slave.
interface gpio_apb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*32-1:0]     req_wdata;
    logic [NUM_REQ*4-1:0]      req_strb;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      rsp_slverr;
    logic [ADDR_W-1:0]         paddr;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [3:0]                pstrb;
    logic [31:0]               pwdata;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output paddr, pwrite, psel, penable, pstrb, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  paddr, pwrite, psel, penable, pstrb, pwdata
    );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Round-robin arbiter feeding one APB master sequencer in front of the GPIO register slave.
// Each accepted command runs SETUP/ACCESS; a wait-state timeout aborts a stalled transfer.
module gpio_apb_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gpio_apb_arbiter_if.master   bus
);
    localparam int unsigned N     = NUM_REQ;
    localparam int PTR_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [31:0]        r_rdata;
    logic               r_slverr;

    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_cand;
    logic               w_found;
    logic               w_accept;
    logic               w_done;
    logic               w_abort;
    int unsigned        w_idx;

    // First valid requester strictly after the pointer, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_idx    = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx = 32'(r_ptr) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            w_cand = PTR_W'(w_idx);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIMIT)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= PTR_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_slverr    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_ptr   <= w_winner;
                r_owner <= w_winner;
                r_write <= bus.req_write[w_winner];
                r_addr  <= bus.req_addr[w_winner*ADDR_W +: ADDR_W];
                r_wdata <= bus.req_wdata[w_winner*32 +: 32];
                r_strb  <= bus.req_write[w_winner] ? bus.req_strb[w_winner*4 +: 4] : 4'h0;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !bus.pready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_rsp_valid <= NUM_REQ'(1) << r_owner;
                r_rdata     <= r_write ? 32'h0 : bus.prdata;
                r_slverr    <= bus.pslverr;
            end else if (w_abort) begin
                r_rsp_valid <= NUM_REQ'(1) << r_owner;
                r_rdata     <= 32'h0;
                r_slverr    <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
    assign bus.psel       = (r_state != S_IDLE);
    assign bus.penable    = (r_state == S_ACCESS);
    assign bus.paddr      = r_addr;
    assign bus.pwrite     = r_write;
    assign bus.pwdata     = r_wdata;
    assign bus.pstrb      = r_strb;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rdata;
    assign bus.rsp_slverr = r_slverr;
endmodule
